// File: rtl/handshake_receiver.sv
// ============================================================================
// Module   : handshake_receiver
// Brief    : Receive endpoint of a 4-phase req/ack CDC; presents the captured
//            word on a valid/ready stream, counts transfers, flags violations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_receiver #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_ack,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_busy,
    output logic                   o_proto_err,
    output logic [COUNT_WIDTH-1:0] o_xfer_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam logic [3:0] c_delay_init = 4'(CAPTURE_DELAY);

    state_t                 r_state;
    logic [3:0]             r_delay;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic                   r_ack;
    logic                   r_busy;
    logic                   r_proto_err;
    logic                   r_req_lost;
    logic [COUNT_WIDTH-1:0] r_count;

    state_t                 w_state_next;
    logic [3:0]             w_delay_next;
    logic [DATA_WIDTH-1:0]  w_data_next;
    logic                   w_valid_next;
    logic                   w_ack_next;
    logic                   w_err_next;
    logic                   w_req_lost_next;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic                   w_lost_now;

    // Sender has dropped req during this presentation (now or earlier).
    assign w_lost_now = r_req_lost | ~i_req;

    always_comb begin
        w_state_next    = r_state;
        w_delay_next    = r_delay;
        w_data_next     = r_data;
        w_valid_next    = r_valid;
        w_ack_next      = r_ack;
        w_err_next      = r_proto_err;
        w_req_lost_next = r_req_lost;
        w_count_next    = r_count;

        case (r_state)
            ST_IDLE: begin
                w_ack_next      = 1'b0;
                w_valid_next    = 1'b0;
                w_req_lost_next = 1'b0;
                if (i_req) begin
                    if (CAPTURE_DELAY == 0) begin
                        w_data_next  = i_data;
                        w_valid_next = 1'b1;
                        w_state_next = ST_PRESENT;
                    end else begin
                        w_delay_next = c_delay_init;
                        w_state_next = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                w_delay_next = r_delay - 4'd1;
                if (!i_req) begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_delay <= 4'd1) begin
                    w_data_next  = i_data;
                    w_valid_next = 1'b1;
                    w_state_next = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                if (!i_req) begin
                    w_err_next = 1'b1;
                end
                if (i_ready) begin
                    w_valid_next    = 1'b0;
                    w_count_next    = r_count + 1'b1;
                    w_req_lost_next = 1'b0;
                    // A sender that already let go must not see an ack.
                    if (w_lost_now) begin
                        w_ack_next   = 1'b0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACK;
                    end
                end else begin
                    w_req_lost_next = w_lost_now;
                end
            end

            ST_ACK: begin
                if (!i_req) begin
                    w_ack_next   = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_delay     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_req_lost  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_delay     <= w_delay_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_ack       <= w_ack_next;
            r_busy      <= (w_state_next != ST_IDLE);
            r_proto_err <= w_err_next;
            r_req_lost  <= w_req_lost_next;
            r_count     <= w_count_next;
        end
    end

    assign o_ack        = r_ack;
    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_busy       = r_busy;
    assign o_proto_err  = r_proto_err;
    assign o_xfer_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_handshake_receiver.sv
// ============================================================================
// Module   : tb_handshake_receiver
// Brief    : Self-checking bench; dut_a uses CAPTURE_DELAY=1, dut_b uses
//            CAPTURE_DELAY=3 with a 2-bit counter. Revision : 1.0
// ============================================================================
`default_nettype none

module tb_handshake_receiver;

    localparam logic [1:0] WRAP_EXP [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, ready_a, ack_a, valid_a, busy_a, err_a;
    logic [31:0] data_a, odata_a;
    logic [15:0] cnt_a;
    logic        req_b, ready_b, ack_b, valid_b, busy_b, err_b;
    logic [31:0] data_b, odata_b;
    logic [1:0]  cnt_b;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    handshake_receiver #(.DATA_WIDTH(32), .COUNT_WIDTH(16), .CAPTURE_DELAY(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_data(data_a),
        .o_ack(ack_a), .o_valid(valid_a), .i_ready(ready_a), .o_data(odata_a),
        .o_busy(busy_a), .o_proto_err(err_a), .o_xfer_count(cnt_a)
    );

    handshake_receiver #(.DATA_WIDTH(32), .COUNT_WIDTH(2), .CAPTURE_DELAY(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_data(data_b),
        .o_ack(ack_b), .o_valid(valid_b), .i_ready(ready_b), .o_data(odata_b),
        .o_busy(busy_b), .o_proto_err(err_b), .o_xfer_count(cnt_b)
    );

    // Scoreboards: a word is popped in the cycle its acceptance edge is due.
    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                $display("FAIL sb_a: unexpected word %h, required none", odata_a);
            end else begin
                exp_a = q_a.pop_front();
                if (odata_a !== exp_a)
                    $display("FAIL sb_a: word %h, required %h", odata_a, exp_a);
                else
                    n_pass++;
            end
        end
        if (!rst && valid_b && ready_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                $display("FAIL sb_b: unexpected word %h, required none", odata_b);
            end else begin
                exp_b = q_b.pop_front();
                if (odata_b !== exp_b)
                    $display("FAIL sb_b: word %h, required %h", odata_b, exp_b);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        q_a.delete(); q_b.delete();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic send_word_a(input logic [31:0] w);
        q_a.push_back(w);
        data_a = w; req_a = 1'b1;
        for (int k = 0; k < 20 && !ack_a; k++) tick();
        n_checks++;
        if (ack_a !== 1'b1) $display("FAIL ack_a_rise: ack %b, required 1", ack_a);
        else n_pass++;
        req_a = 1'b0;
        for (int k = 0; k < 20 && ack_a; k++) tick();
        n_checks++;
        if (ack_a !== 1'b0) $display("FAIL ack_a_fall: ack %b, required 0", ack_a);
        else n_pass++;
    endtask

    task automatic send_word_b(input logic [31:0] w);
        q_b.push_back(w);
        data_b = w; req_b = 1'b1;
        for (int k = 0; k < 20 && !ack_b; k++) tick();
        n_checks++;
        if (ack_b !== 1'b1) $display("FAIL ack_b_rise: ack %b, required 1", ack_b);
        else n_pass++;
        req_b = 1'b0;
        for (int k = 0; k < 20 && ack_b; k++) tick();
        n_checks++;
        if (ack_b !== 1'b0) $display("FAIL ack_b_fall: ack %b, required 0", ack_b);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_a = 1'b1; req_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        data_a = 32'hFFFF_FFFF; data_b = 32'hFFFF_FFFF;
        tick(); tick();
        n_checks++;
        if ({ack_a, valid_a, busy_a, err_a} !== 4'b0000)
            $display("FAIL reset_ctl_a: %b, required 0000", {ack_a, valid_a, busy_a, err_a});
        else n_pass++;
        n_checks++;
        if ({cnt_a, odata_a} !== 48'h0)
            $display("FAIL reset_dat_a: cnt %h data %h, required 0 0", cnt_a, odata_a);
        else n_pass++;
        n_checks++;
        if ({ack_b, valid_b, busy_b, err_b, cnt_b, odata_b} !== 38'h0)
            $display("FAIL reset_b: %h, required 0", {ack_b, valid_b, busy_b, err_b, cnt_b, odata_b});
        else n_pass++;
        req_a = 1'b0; req_b = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        ready_a = 1'b1; data_a = 32'hDEAD_BEEF; req_a = 1'b1;
        q_a.push_back(32'hDEAD_BEEF);
        tick();
        n_checks++;
        if ({valid_a, busy_a, ack_a} !== 3'b010)
            $display("FAIL basic_e0: valid/busy/ack %b, required 010", {valid_a, busy_a, ack_a});
        else n_pass++;
        tick();
        n_checks++;
        if ({valid_a, busy_a, ack_a, odata_a} !== {3'b110, 32'hDEAD_BEEF})
            $display("FAIL basic_present: v/b/a %b data %h, required 110 deadbeef",
                     {valid_a, busy_a, ack_a}, odata_a);
        else n_pass++;
        tick();
        n_checks++;
        if ({valid_a, busy_a, ack_a, cnt_a} !== {3'b011, 16'd1})
            $display("FAIL basic_ack: v/b/a %b cnt %0d, required 011 1", {valid_a, busy_a, ack_a}, cnt_a);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({valid_a, ack_a} !== 2'b01)
            $display("FAIL basic_ack_hold: valid/ack %b, required 01", {valid_a, ack_a});
        else n_pass++;
        req_a = 1'b0;
        tick();
        n_checks++;
        if ({ack_a, busy_a, err_a, cnt_a} !== {3'b000, 16'd1})
            $display("FAIL basic_release: a/b/e %b cnt %0d, required 000 1", {ack_a, busy_a, err_a}, cnt_a);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        data_a = 32'hA5A5_0001; req_a = 1'b1;
        q_a.push_back(32'hA5A5_0001);
        for (int k = 0; k < 20 && !valid_a; k++) tick();
        n_checks++;
        if (valid_a !== 1'b1) $display("FAIL bp_valid: valid %b, required 1", valid_a);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            data_a = $urandom;
            tick();
            n_checks++;
            if ({valid_a, ack_a, odata_a} !== {2'b10, 32'hA5A5_0001})
                $display("FAIL bp_hold: v/a %b data %h, required 10 a5a50001", {valid_a, ack_a}, odata_a);
            else n_pass++;
        end
        ready_a = 1'b1;
        tick();
        n_checks++;
        if ({valid_a, ack_a, cnt_a} !== {2'b01, 16'd1})
            $display("FAIL bp_accept: v/a %b cnt %0d, required 01 1", {valid_a, ack_a}, cnt_a);
        else n_pass++;
        req_a = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({ack_a, valid_a, cnt_a} !== {2'b00, 16'd1})
            $display("FAIL bp_once: a/v %b cnt %0d, required 00 1", {ack_a, valid_a}, cnt_a);
        else n_pass++;
    endtask

    task automatic test_req_drop_present();
        do_reset();
        data_a = 32'h1234_5678; req_a = 1'b1;
        q_a.push_back(32'h1234_5678);
        for (int k = 0; k < 20 && !valid_a; k++) tick();
        req_a = 1'b0;
        tick(); tick();
        n_checks++;
        if ({valid_a, err_a, ack_a, odata_a} !== {3'b110, 32'h1234_5678})
            $display("FAIL drop_present: v/e/a %b data %h, required 110 12345678",
                     {valid_a, err_a, ack_a}, odata_a);
        else n_pass++;
        ready_a = 1'b1;
        tick();
        n_checks++;
        if ({valid_a, ack_a, busy_a, err_a, cnt_a} !== {4'b0001, 16'd1})
            $display("FAIL drop_accept: v/a/b/e %b cnt %0d, required 0001 1",
                     {valid_a, ack_a, busy_a, err_a}, cnt_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_a = 1'b1;
        for (int i = 1; i <= 5; i++) send_word_a(32'(i));
        n_checks++;
        if ({cnt_a, err_a} !== {16'd5, 1'b0})
            $display("FAIL b2b_count: cnt %0d err %b, required 5 0", cnt_a, err_a);
        else n_pass++;
        n_checks++;
        if (q_a.size() !== 0) $display("FAIL b2b_drain: %0d words left, required 0", q_a.size());
        else n_pass++;
    endtask

    task automatic test_early_drop();
        do_reset();
        ready_b = 1'b1; data_b = 32'h0BAD_0BAD; req_b = 1'b1;
        tick(); tick();
        req_b = 1'b0;
        tick();
        n_checks++;
        if ({err_b, valid_b, busy_b} !== 3'b100)
            $display("FAIL early_err: e/v/b %b, required 100", {err_b, valid_b, busy_b});
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({valid_b, err_b, cnt_b} !== {2'b01, 2'd0})
                $display("FAIL early_idle: v/e %b cnt %0d, required 01 0", {valid_b, err_b}, cnt_b);
            else n_pass++;
        end
        send_word_b(32'h0000_0077);
        n_checks++;
        if ({err_b, cnt_b} !== {1'b1, 2'd1})
            $display("FAIL early_sticky: err %b cnt %0d, required 1 1", err_b, cnt_b);
        else n_pass++;
        do_reset();
        n_checks++;
        if (err_b !== 1'b0) $display("FAIL early_clear: err %b, required 0", err_b);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        ready_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_word_b(32'h100 + 32'(i));
            n_checks++;
            if (cnt_b !== WRAP_EXP[i])
                $display("FAIL wrap_%0d: cnt %0d, required %0d", i, cnt_b, WRAP_EXP[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_ack();
        do_reset();
        ready_a = 1'b1; data_a = 32'hCAFE_F00D; req_a = 1'b1;
        q_a.push_back(32'hCAFE_F00D);
        for (int k = 0; k < 20 && !ack_a; k++) tick();
        n_checks++;
        if (ack_a !== 1'b1) $display("FAIL rack_ack: ack %b, required 1", ack_a);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ack_a, valid_a, busy_a, err_a, cnt_a, odata_a} !== 52'h0)
            $display("FAIL rack_cleared: %h, required 0", {ack_a, valid_a, busy_a, err_a, cnt_a, odata_a});
        else n_pass++;
        q_a.push_back(32'hCAFE_F00D);
        for (int k = 0; k < 20 && !valid_a; k++) tick();
        n_checks++;
        if ({valid_a, odata_a} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL rack_redeliver: v %b data %h, required 1 cafef00d", valid_a, odata_a);
        else n_pass++;
        for (int k = 0; k < 20 && !ack_a; k++) tick();
        n_checks++;
        if ({ack_a, cnt_a} !== {1'b1, 16'd1})
            $display("FAIL rack_count: ack %b cnt %0d, required 1 1", ack_a, cnt_a);
        else n_pass++;
        req_a = 1'b0;
        tick();
        n_checks++;
        if ({ack_a, q_a.size() == 0} !== 2'b01)
            $display("FAIL rack_end: ack %b drained %b, required 0 1", ack_a, q_a.size() == 0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        data_a = '0; data_b = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_req_drop_present();
        test_back_to_back();
        test_early_drop();
        test_wrap();
        test_reset_in_ack();
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/handshake_receiver.md
# handshake_receiver

Receive-side endpoint of the 4-phase req/ack clock-domain crossing. It sits in the receiving clock domain, behind the dual-FF resync of the sender's valid. It captures the sender's held data word, presents it to local logic on a valid/ready stream, and drives the ack that is resynced back to the sender. The block also counts completed transfers and flags sender protocol violations.

## Interface

Parameters:
- DATA_WIDTH, 32: width of the crossed data word.
- COUNT_WIDTH, 16: width of the transfer counter.
- CAPTURE_DELAY, 1: number of extra cycles between first seeing i_req high and sampling i_data (skew margin). Legal range is 0..15.

Ports:
- i_clk, input, 1: receive-domain clock. This is the block's only clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_req, input, 1: sender valid, already synchronized into i_clk by the resync.
- i_data, input, DATA_WIDTH: sender data. Held stable by the sender while its valid is high and until it sees ack.
- o_ack, output, 1: ack to the resync (toward the sender domain).
- o_valid, output, 1: local stream valid.
- i_ready, input, 1: local stream ready.
- o_data, output, DATA_WIDTH: local stream data, registered.
- o_busy, output, 1: high in every state except IDLE.
- o_proto_err, output, 1: sticky protocol-violation flag.
- o_xfer_count, output, COUNT_WIDTH: number of words delivered. Wraps modulo 2^COUNT_WIDTH.

## Operation

- States are IDLE, SETTLE, PRESENT and ACK. All state and outputs are registered.
- IDLE:
  - o_ack=0, o_valid=0.
  - On i_req=1 with CAPTURE_DELAY=0: o_data<=i_data, o_valid<=1, go to PRESENT.
  - On i_req=1 with CAPTURE_DELAY>0: load the delay counter with CAPTURE_DELAY, go to SETTLE.
- SETTLE:
  - Decrement the delay counter each cycle.
  - At the edge where the counter reaches 0 with i_req=1: o_data<=i_data, o_valid<=1, go to PRESENT.
  - If i_req is sampled 0 in SETTLE: set o_proto_err, return to IDLE. No output, no count.
- PRESENT:
  - o_valid=1 and o_data are held stable until i_ready=1. Valid never drops without acceptance.
  - On acceptance: o_valid<=0, o_xfer_count<=o_xfer_count+1, o_ack<=1, go to ACK.
  - If i_req is sampled 0 while in PRESENT: set o_proto_err and keep presenting. On acceptance, still count the word, but leave o_ack=0 and go straight to IDLE.
- ACK:
  - o_ack=1 until i_req is sampled 0. Then o_ack<=0, go to IDLE.
  - i_req held high is not an error. ACK waits indefinitely.
- o_proto_err is only ever set by the conditions above and is cleared only by i_rst.

## Timing

- Reset: at any edge with i_rst=1, the state goes to IDLE and every output is forced low: o_ack, o_valid, o_busy, o_proto_err, o_xfer_count, o_data.
- Reset mid-transfer abandons the transfer.
  - If i_req is still high after reset, a new transfer starts from IDLE. Duplicate delivery in this case is accepted behaviour.
- Capture latency: let E0 be the first edge where IDLE samples i_req=1.
  - i_data is sampled at edge E0+CAPTURE_DELAY.
  - o_valid is high starting in the cycle after that edge.
- Ack latency: o_ack rises in the cycle after the accepting edge (o_valid & i_ready). The minimum is one cycle after o_valid, with i_ready held high.
- Release latency: o_ack falls in the cycle after the edge that samples i_req=0 in ACK.
  - The next transfer can be detected no earlier than the edge after o_ack falls.
- Full transfer with CAPTURE_DELAY=1 and i_ready high: o_valid is high for 1 cycle, starting 2 cycles after E0.
- o_busy is registered with the state and is high from the cycle after E0 until the cycle after returning to IDLE.
- Simultaneous events:
  - Acceptance and i_req=0 on the same edge in PRESENT is treated as a protocol error: count the word, no ack, go to IDLE.
  - A counter wrap on acceptance goes from 2^COUNT_WIDTH-1 to 0, with no flag.

## Test plan

- Basic transfer: DATA_WIDTH=32, CAPTURE_DELAY=1, i_ready=1. Drive i_req=1 with i_data=0xDEADBEEF, then drop i_req 3 cycles after o_ack rises.
  - Required: o_data=0xDEADBEEF with o_valid high for 1 cycle, o_xfer_count=1, o_ack high until one cycle after i_req falls, o_proto_err=0.
- Backpressure: hold i_ready=0 for 10 cycles while o_valid=1, and change i_data during that window.
  - Required: o_data is unchanged, o_ack stays 0 until acceptance, and the count increments exactly once.
- Early req drop: CAPTURE_DELAY=3, pulse i_req high for 2 cycles.
  - Required: no o_valid, count=0, o_proto_err=1 and it stays 1 until i_rst.
- Back-to-back transfers: 5 words 0x1..0x5 with the sender obeying the 4-phase protocol.
  - Required: words are delivered in order, o_xfer_count=5, and o_ack returns to 0 between every pair of words.
- Counter wrap: COUNT_WIDTH=2, run 5 transfers.
  - Required: o_xfer_count sequence is 1, 2, 3, 0, 1.
- Reset in ACK state: assert i_rst for 1 cycle while o_ack=1 and i_req=1.
  - Required: all outputs are 0 in the next cycle, then a new transfer starts and delivers the held i_data again.
